data_path: RTL and testbench

- 32-bit single-bus CPU datapath for Phase 1 of the processor.
- Contains 16 general registers (R0–R15), HI, LO, PC, IR, MAR, MDR, Y and a 64-bit Z result register. All are linked by one shared 32-bit bus.
- A combinational ALU takes Y and the bus as operands and writes Z. The control unit (or a testbench) drives all out/in/opcode strobes directly.

---
 rtl/data_path.sv | 192 +++++++++++++++++++
 tb/tb_data_path.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath: general registers, HI/LO, PC, IR, MAR, MDR,
// Y and a 64-bit Z register around one shared bus and a combinational ALU.
module data_path #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             read,
    input  logic             R0out,
    input  logic             R1out,
    input  logic             R2out,
    input  logic             R3out,
    input  logic             R4out,
    input  logic             R5out,
    input  logic             R6out,
    input  logic             R7out,
    input  logic             R8out,
    input  logic             R9out,
    input  logic             R10out,
    input  logic             R11out,
    input  logic             R12out,
    input  logic             R13out,
    input  logic             R14out,
    input  logic             R15out,
    input  logic             R0in,
    input  logic             R1in,
    input  logic             R2in,
    input  logic             R3in,
    input  logic             R4in,
    input  logic             R5in,
    input  logic             R6in,
    input  logic             R7in,
    input  logic             R8in,
    input  logic             R9in,
    input  logic             R10in,
    input  logic             R11in,
    input  logic             R12in,
    input  logic             R13in,
    input  logic             R14in,
    input  logic             R15in,
    input  logic             HIout,
    input  logic             HIin,
    input  logic             LOout,
    input  logic             LOin,
    input  logic             Zhighout,
    input  logic             Zlowout,
    input  logic             Zin,
    input  logic             Yin,
    input  logic             MDRout,
    input  logic             MDRin,
    input  logic             MARin,
    input  logic             PCout,
    input  logic             PCin,
    input  logic             IRin,
    input  logic             IncPC,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic [4:0]       opcode,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] BusMuxIn_MDR,
    output logic [WIDTH-1:0] MDRMuxOut
);

    localparam int SHW = $clog2(WIDTH);

    logic [NREGS-1:0]   r_out;
    logic [NREGS-1:0]   r_in;
    logic [WIDTH-1:0]   r_q [NREGS];
    logic [WIDTH-1:0]   r_d [NREGS];
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   pc_q, pc_d, ir_q, ir_d;
    logic [WIDTH-1:0]   mar_q, mar_d, mdr_q, mdr_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [2*WIDTH-1:0] z_q, z_d;

    logic [WIDTH-1:0]   bus;
    logic [WIDTH-1:0]   alu_a, alu_b;
    logic [2*WIDTH-1:0] alu_c;
    logic [SHW-1:0]     sh;
    logic [2*WIDTH-1:0] dbl, rot_r, rot_l, prod;
    logic signed [WIDTH-1:0] sa, sb, quo, rem;

    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

    // Lowest-numbered source wins when strobes collide
    always_comb begin
        bus = '0;
        if (|r_out) begin
            for (int i = NREGS - 1; i >= 0; i--) begin
                if (r_out[i]) bus = r_q[i];
            end
        end else if (HIout) begin
            bus = hi_q;
        end else if (LOout) begin
            bus = lo_q;
        end else if (Zhighout) begin
            bus = z_q[2*WIDTH-1:WIDTH];
        end else if (Zlowout) begin
            bus = z_q[WIDTH-1:0];
        end else if (PCout) begin
            bus = pc_q;
        end else if (MDRout) begin
            bus = mdr_q;
        end
    end

    assign BusMuxOut    = bus;
    assign BusMuxIn_MDR = mdr_q;
    assign MDRMuxOut    = read ? Mdatain : bus;

    assign alu_a = y_q;
    assign alu_b = bus;
    assign sh    = alu_b[SHW-1:0];
    assign dbl   = {alu_a, alu_a};
    assign rot_r = dbl >> sh;
    assign rot_l = dbl << sh;
    assign prod  = {{WIDTH{alu_a[WIDTH-1]}}, alu_a} * {{WIDTH{alu_b[WIDTH-1]}}, alu_b};
    assign sa    = alu_a;
    assign sb    = alu_b;
    assign quo   = sa / sb;
    assign rem   = sa % sb;

    always_comb begin
        alu_c = '0;
        if (IncPC) begin
            alu_c[WIDTH-1:0] = alu_b + WIDTH'(1);
        end else begin
            case (opcode)
                5'b00011: alu_c[WIDTH-1:0] = alu_a + alu_b;
                5'b00100: alu_c[WIDTH-1:0] = alu_a - alu_b;
                5'b00101: alu_c[WIDTH-1:0] = alu_a & alu_b;
                5'b00110: alu_c[WIDTH-1:0] = alu_a | alu_b;
                5'b00111: alu_c[WIDTH-1:0] = rot_r[WIDTH-1:0];
                5'b01000: alu_c[WIDTH-1:0] = rot_l[2*WIDTH-1:WIDTH];
                5'b01001: alu_c[WIDTH-1:0] = alu_a >> sh;
                5'b01010: alu_c[WIDTH-1:0] = $unsigned(sa >>> sh);
                5'b01011: alu_c[WIDTH-1:0] = alu_a << sh;
                5'b01111: begin
                    // Divide by zero: all-ones quotient, dividend as remainder
                    if (alu_b == '0) alu_c = {alu_a, {WIDTH{1'b1}}};
                    else             alu_c = {$unsigned(rem), $unsigned(quo)};
                end
                5'b10000: alu_c = prod;
                5'b10001: alu_c[WIDTH-1:0] = '0 - alu_b;
                5'b10010: alu_c[WIDTH-1:0] = ~alu_b;
                default:  alu_c = '0;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            r_d[i] = r_in[i] ? bus : r_q[i];
        end
        hi_d  = HIin  ? bus : hi_q;
        lo_d  = LOin  ? bus : lo_q;
        pc_d  = PCin  ? bus : pc_q;
        ir_d  = IRin  ? bus : ir_q;
        mar_d = MARin ? bus : mar_q;
        mdr_d = MDRin ? MDRMuxOut : mdr_q;
        y_d   = Yin   ? bus : y_q;
        z_d   = Zin   ? alu_c : z_q;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NREGS; i++) r_q[i] <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) r_q[i] <= r_d[i];
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            z_q   <= z_d;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: directed transfer sequences, an ALU vector table and
// randomized ALU operations against a reference model.
module tb_data_path;

    logic        clock;
    logic        clear;
    logic        read;
    logic [15:0] rout, rin;
    logic        HIout, HIin, LOout, LOin, Zhighout, Zlowout, Zin, Yin;
    logic        MDRout, MDRin, MARin, PCout, PCin, IRin, IncPC;
    logic [31:0] Mdatain;
    logic [4:0]  opcode;
    logic [31:0] BusMuxOut, BusMuxIn_MDR, MDRMuxOut;

    int checks = 0;
    int errors = 0;

    data_path dut (
        .clock(clock), .clear(clear), .read(read),
        .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
        .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
        .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
        .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
        .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .HIout(HIout), .HIin(HIin), .LOout(LOout), .LOin(LOin),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .Zin(Zin), .Yin(Yin),
        .MDRout(MDRout), .MDRin(MDRin), .MARin(MARin),
        .PCout(PCout), .PCin(PCin), .IRin(IRin), .IncPC(IncPC),
        .Mdatain(Mdatain), .opcode(opcode),
        .BusMuxOut(BusMuxOut), .BusMuxIn_MDR(BusMuxIn_MDR), .MDRMuxOut(MDRMuxOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic        inc;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] c;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic idle();
        rout = '0; rin = '0;
        HIout = 0; HIin = 0; LOout = 0; LOin = 0;
        Zhighout = 0; Zlowout = 0; Zin = 0; Yin = 0;
        MDRout = 0; MDRin = 0; MARin = 0; PCout = 0; PCin = 0; IRin = 0;
        IncPC = 0; read = 0; Mdatain = '0; opcode = '0;
    endtask

    // Source codes: 0..15 Rn, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR
    task automatic set_out(input int s);
        case (s)
            16: HIout = 1;
            17: LOout = 1;
            18: Zhighout = 1;
            19: Zlowout = 1;
            20: PCout = 1;
            21: MDRout = 1;
            default: rout[s] = 1;
        endcase
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic bus_rd(input int s, output logic [31:0] v);
        idle();
        set_out(s);
        #1;
        v = BusMuxOut;
        idle();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        read = 1; Mdatain = v; MDRin = 1;
        step();
    endtask

    task automatic alu_run(input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op, input logic inc,
                           output logic [63:0] z);
        logic [31:0] lo, hi;
        load_mdr(a);
        MDRout = 1; Yin = 1;
        step();
        load_mdr(b);
        MDRout = 1; opcode = op; IncPC = inc; Zin = 1;
        step();
        bus_rd(19, lo);
        bus_rd(18, hi);
        z = {hi, lo};
    endtask

    function automatic logic [63:0] model(input logic [4:0] op, input logic inc,
                                          input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        logic [63:0] aa, t;
        longint sa, sb, q, r;
        s  = b % 32;
        aa = {a, a};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (inc) return {32'h0, b + 32'd1};
        case (op)
            5'd3:  return {32'h0, a + b};
            5'd4:  return {32'h0, a - b};
            5'd5:  return {32'h0, a & b};
            5'd6:  return {32'h0, a | b};
            5'd7:  begin t = aa >> s; return {32'h0, t[31:0]}; end
            5'd8:  begin t = aa << s; return {32'h0, t[63:32]}; end
            5'd9:  return {32'h0, a >> s};
            5'd10: begin t = sa >>> s; return {32'h0, t[31:0]}; end
            5'd11: return {32'h0, a << s};
            5'd15: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa - q * sb;
                return {r[31:0], q[31:0]};
            end
            5'd16: return sa * sb;
            5'd17: return {32'h0, 32'h0 - b};
            5'd18: return {32'h0, ~b};
            default: return 64'h0;
        endcase
    endfunction

    initial begin
        logic [31:0] v;
        logic [63:0] z;
        logic [4:0]  ops[14];

        tv.push_back('{"add",      5'd3,  1'b0, 32'h0000_0FF5, 32'h0000_0028, 64'h0000_0000_0000_101D});
        tv.push_back('{"sub",      5'd4,  1'b0, 32'h0000_0005, 32'h0000_0007, 64'h0000_0000_FFFF_FFFE});
        tv.push_back('{"and",      5'd5,  1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 64'h0000_0000_00F0_1200});
        tv.push_back('{"or",       5'd6,  1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 64'h0000_0000_FFF0_FF34});
        tv.push_back('{"ror1",     5'd7,  1'b0, 32'h0000_0001, 32'h0000_0001, 64'h0000_0000_8000_0000});
        tv.push_back('{"ror0",     5'd7,  1'b0, 32'h1234_5678, 32'h0000_0000, 64'h0000_0000_1234_5678});
        tv.push_back('{"rol4",     5'd8,  1'b0, 32'h8000_0001, 32'h0000_0004, 64'h0000_0000_0000_0018});
        tv.push_back('{"shr_b5",   5'd9,  1'b0, 32'h8000_0000, 32'h0000_0021, 64'h0000_0000_4000_0000});
        tv.push_back('{"shra",     5'd10, 1'b0, 32'h8000_0000, 32'h0000_0001, 64'h0000_0000_C000_0000});
        tv.push_back('{"shl31",    5'd11, 1'b0, 32'h0000_0003, 32'h0000_001F, 64'h0000_0000_8000_0000});
        tv.push_back('{"div_neg",  5'd15, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD});
        tv.push_back('{"div_zero", 5'd15, 1'b0, 32'h0000_1234, 32'h0000_0000, 64'h0000_1234_FFFF_FFFF});
        tv.push_back('{"mul_big",  5'd16, 1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000});
        tv.push_back('{"neg",      5'd17, 1'b0, 32'h0000_0000, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF});
        tv.push_back('{"not",      5'd18, 1'b0, 32'h0000_0000, 32'h0F0F_0F0F, 64'h0000_0000_F0F0_F0F0});
        tv.push_back('{"op_0",     5'd0,  1'b0, 32'h1111_1111, 32'h2222_2222, 64'h0});
        tv.push_back('{"op_31",    5'd31, 1'b0, 32'h1111_1111, 32'h2222_2222, 64'h0});
        tv.push_back('{"inc_wrap", 5'd3,  1'b1, 32'h0000_0005, 32'hFFFF_FFFF, 64'h0});
        tv.push_back('{"inc",      5'd16, 1'b1, 32'h0000_0005, 32'h0000_0007, 64'h0000_0000_0000_0008});

        idle();
        clear = 0;
        #12;
        for (int s = 0; s < 22; s++) begin
            bus_rd(s, v);
            chk($sformatf("reset_src%0d", s), {32'h0, v}, 64'h0);
        end
        chk("reset_mar", {32'h0, dut.mar_q}, 64'h0);
        chk("reset_ir", {32'h0, dut.ir_q}, 64'h0);
        chk("reset_y", {32'h0, dut.y_q}, 64'h0);
        #1;
        chk("reset_bus_idle", {32'h0, BusMuxOut}, 64'h0);
        clear = 1;

        load_mdr(32'h0000_0FF5);
        chk("mdr_ff5", {32'h0, BusMuxIn_MDR}, 64'hFF5);
        MDRout = 1; rin[2] = 1; step();
        bus_rd(2, v); chk("r2", {32'h0, v}, 64'hFF5);
        load_mdr(32'hFFFF_FFFD);
        MDRout = 1; rin[6] = 1; step();
        bus_rd(6, v); chk("r6", {32'h0, v}, 64'hFFFF_FFFD);
        load_mdr(32'h0000_0028);
        MDRout = 1; rin[4] = 1; step();
        bus_rd(4, v); chk("r4", {32'h0, v}, 64'h28);

        PCout = 1; MARin = 1; IncPC = 1; Zin = 1; step();
        chk("fetch_mar", {32'h0, dut.mar_q}, 64'h0);
        bus_rd(19, v); chk("fetch_z", {32'h0, v}, 64'h1);
        Zlowout = 1; PCin = 1; read = 1; Mdatain = 32'h2A2B_8000; MDRin = 1; step();
        bus_rd(20, v); chk("fetch_pc", {32'h0, v}, 64'h1);
        chk("fetch_mdr", {32'h0, BusMuxIn_MDR}, 64'h2A2B_8000);
        MDRout = 1; IRin = 1; step();
        chk("fetch_ir", {32'h0, dut.ir_q}, 64'h2A2B_8000);

        rout[2] = 1; Yin = 1; step();
        rout[6] = 1; opcode = 5'b01111; Zin = 1; step();
        Zlowout = 1; LOin = 1; step();
        Zhighout = 1; HIin = 1; step();
        bus_rd(17, v); chk("div_lo", {32'h0, v}, 64'hFFFF_FAAF);
        bus_rd(16, v); chk("div_hi", {32'h0, v}, 64'h2);

        rout[6] = 1; Yin = 1; step();
        rout[4] = 1; opcode = 5'b10000; Zin = 1; step();
        bus_rd(18, v); chk("mul_hi", {32'h0, v}, 64'hFFFF_FFFF);
        bus_rd(19, v); chk("mul_lo", {32'h0, v}, 64'hFFFF_FF88);

        rout[2] = 1; Yin = 1; step();
        rout[4] = 1; opcode = 5'b00011; Zin = 1; step();
        bus_rd(19, v); chk("add_seq", {32'h0, v}, 64'h101D);

        rout[2] = 1; rout[4] = 1; #1;
        chk("prio_r2_r4", {32'h0, BusMuxOut}, 64'hFF5);
        idle(); rout[4] = 1; HIout = 1; #1;
        chk("prio_r4_hi", {32'h0, BusMuxOut}, 64'h28);
        idle(); HIout = 1; PCout = 1; #1;
        chk("prio_hi_pc", {32'h0, BusMuxOut}, 64'h2);
        idle(); rout[4] = 1; read = 0; #1;
        chk("mdrmux_bus", {32'h0, MDRMuxOut}, 64'h28);
        read = 1; Mdatain = 32'h77; #1;
        chk("mdrmux_mem", {32'h0, MDRMuxOut}, 64'h77);
        idle();

        for (int i = 0; i < tv.size(); i++) begin
            alu_run(tv[i].a, tv[i].b, tv[i].op, tv[i].inc, z);
            chk(tv[i].name, z, tv[i].c);
        end

        ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                5'd11, 5'd15, 5'd16, 5'd17, 5'd18, 5'd0};
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            logic [4:0]  op;
            logic        inc;
            a   = $urandom;
            b   = $urandom;
            op  = ops[$urandom_range(0, 13)];
            if ($urandom_range(0, 9) == 0) op = 5'($urandom);
            inc = ($urandom_range(0, 7) == 0);
            if (op == 5'd15 && $urandom_range(0, 5) == 0) b = 32'h0;
            if (op == 5'd15 && $urandom_range(0, 5) == 0) b = b % 16;
            if (op == 5'd15 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'h3;
            alu_run(a, b, op, inc, z);
            chk($sformatf("rand%0d_op%0d_inc%0d", i, op, inc), z, model(op, inc, a, b));
        end

        load_mdr(32'h0000_ABCD);
        MDRout = 1; rin[5] = 1; read = 1; Mdatain = 32'h5; MDRin = 1;
        @(negedge clock);
        clear = 0;
        #1;
        chk("async_clr_mdr", {32'h0, BusMuxIn_MDR}, 64'h0);
        @(posedge clock);
        #1;
        chk("clr_hold_mdr", {32'h0, BusMuxIn_MDR}, 64'h0);
        idle();
        #1;
        clear = 1;
        bus_rd(5, v); chk("clr_r5", {32'h0, v}, 64'h0);
        bus_rd(2, v); chk("clr_r2", {32'h0, v}, 64'h0);
        bus_rd(20, v); chk("clr_pc", {32'h0, v}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
